// File: rtl/hit_judge.sv
// Press-side judge: synchronises the lane keys, edge-detects, applies a per-lane lockout and classifies
// the note window. It drives the event pulses, score and miss count. Define COMBO_EN to add the combo counter.
module hit_judge #(
    parameter int SCORE_W     = 10,
    parameter int GOAL_PTS    = 3,
    parameter int NEAR_PTS    = 1,
    parameter int LOCKOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            key,
    input  logic [15:0][15:0]     pixels,
    output logic                  goal1,
    output logic                  goal2,
    output logic                  goal3,
    output logic                  goal4,
    output logic                  upN1,
    output logic                  upN2,
    output logic                  upN3,
    output logic                  upN4,
    output logic                  downN1,
    output logic                  downN2,
    output logic                  downN3,
    output logic                  downN4,
    output logic [SCORE_W-1:0]    score,
    output logic [7:0]            miss_cnt
`ifdef COMBO_EN
    ,
    output logic [7:0]            combo
`endif
);

    localparam int LW    = $clog2(LOCKOUT_CYC + 1);
    localparam int SUM_W = SCORE_W + 8;

    typedef enum logic [1:0] {
        J_MISS,
        J_GOAL,
        J_UP,
        J_DOWN
    } judge_t;

    logic [3:0]    s1, s2, s3;
    logic [3:0]    press_edge;
    logic [3:0]    accept;
    logic [LW-1:0] lock_cnt [4];
    judge_t        kind_next [4];
    judge_t        j_kind [4];
    logic [3:0]    j_valid;

    logic [3:0]    goal_v, up_v, down_v, miss_v;
    logic [3:0]    goal_q, up_q, down_q;
    logic [2:0]    goal_n, near_n, miss_n;
    int            gpts;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [8:0]    miss_sum;
    logic [7:0]    miss_next;
`ifdef COMBO_EN
    logic [7:0]    combo_next;
`endif

    // Lane n's 2x4 window covers rows row and row+1 over columns 12-4*(n-1) .. 15-4*(n-1).
    function automatic logic zone_hit(input logic [15:0][15:0] px,
                                      input int unsigned row,
                                      input int unsigned lane);
        int unsigned base;
        base = 12 - 4 * lane;
        return (|px[row][base +: 4]) | (|px[row + 1][base +: 4]);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign press_edge = s2 & ~s3;

    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            accept[i] = press_edge[i] && (lock_cnt[i] == '0);
            if (zone_hit(pixels, 2, i))
                kind_next[i] = J_GOAL;
            else if (zone_hit(pixels, 0, i))
                kind_next[i] = J_UP;
            else if (zone_hit(pixels, 4, i))
                kind_next[i] = J_DOWN;
            else
                kind_next[i] = J_MISS;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (reset)
                lock_cnt[i] <= '0;
            else if (accept[i])
                lock_cnt[i] <= LW'(LOCKOUT_CYC);
            else if (lock_cnt[i] != '0)
                lock_cnt[i] <= lock_cnt[i] - 1'b1;
        end
    end

    // Judgement is captured on the accept cycle; the pulse stage follows one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            j_valid <= '0;
            for (int unsigned i = 0; i < 4; i++)
                j_kind[i] <= J_MISS;
        end else begin
            j_valid <= accept;
            for (int unsigned i = 0; i < 4; i++)
                j_kind[i] <= kind_next[i];
        end
    end

    always_comb begin
        goal_v = '0;
        up_v   = '0;
        down_v = '0;
        miss_v = '0;
        goal_n = '0;
        near_n = '0;
        miss_n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            goal_v[i] = j_valid[i] && (j_kind[i] == J_GOAL);
            up_v[i]   = j_valid[i] && (j_kind[i] == J_UP);
            down_v[i] = j_valid[i] && (j_kind[i] == J_DOWN);
            miss_v[i] = j_valid[i] && (j_kind[i] == J_MISS);
            if (goal_v[i])
                goal_n = goal_n + 3'd1;
            if (up_v[i] || down_v[i])
                near_n = near_n + 3'd1;
            if (miss_v[i])
                miss_n = miss_n + 3'd1;
        end
    end

    always_comb begin
`ifdef COMBO_EN
        gpts = (combo >= 8'd4) ? 2 * GOAL_PTS : GOAL_PTS;
        combo_next = combo;
        if (near_n != '0 || miss_n != '0)
            combo_next = '0;
        else if (goal_n != '0 && combo != 8'hff)
            combo_next = combo + 8'd1;
`else
        gpts = GOAL_PTS;
`endif
        score_sum = SUM_W'(score)
                  + SUM_W'(goal_n) * SUM_W'(gpts)
                  + SUM_W'(near_n) * SUM_W'(NEAR_PTS);
        score_next = (score_sum[SUM_W-1:SCORE_W] != '0) ? '1 : score_sum[SCORE_W-1:0];
        miss_sum   = {1'b0, miss_cnt} + 9'(miss_n);
        miss_next  = miss_sum[8] ? 8'hff : miss_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            goal_q   <= '0;
            up_q     <= '0;
            down_q   <= '0;
            score    <= '0;
            miss_cnt <= '0;
`ifdef COMBO_EN
            combo    <= '0;
`endif
        end else begin
            goal_q   <= goal_v;
            up_q     <= up_v;
            down_q   <= down_v;
            score    <= score_next;
            miss_cnt <= miss_next;
`ifdef COMBO_EN
            combo    <= combo_next;
`endif
        end
    end

    assign goal1  = goal_q[0];
    assign goal2  = goal_q[1];
    assign goal3  = goal_q[2];
    assign goal4  = goal_q[3];
    assign upN1   = up_q[0];
    assign upN2   = up_q[1];
    assign upN3   = up_q[2];
    assign upN4   = up_q[3];
    assign downN1 = down_q[0];
    assign downN2 = down_q[1];
    assign downN3 = down_q[2];
    assign downN4 = down_q[3];

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: each accepted press pushes its expected pulses/score/miss_cnt,
// compared on the cycle the pulse is due; any pulse with nothing due is flagged.
module tb_hit_judge;

    localparam int SW = 5;
    localparam int GP = 3;
    localparam int NP = 1;
    localparam int LK = 1024;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       key = '0;
    logic [15:0][15:0] pixels = '0;
    logic goal1, goal2, goal3, goal4;
    logic upN1, upN2, upN3, upN4;
    logic downN1, downN2, downN3, downN4;
    logic [SW-1:0]    score;
    logic [7:0]       miss_cnt;
`ifdef COMBO_EN
    logic [7:0]       combo;
`endif

    hit_judge #(
        .SCORE_W(SW),
        .GOAL_PTS(GP),
        .NEAR_PTS(NP),
        .LOCKOUT_CYC(LK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key(key),
        .pixels(pixels),
        .goal1(goal1), .goal2(goal2), .goal3(goal3), .goal4(goal4),
        .upN1(upN1), .upN2(upN2), .upN3(upN3), .upN4(upN4),
        .downN1(downN1), .downN2(downN2), .downN3(downN3), .downN4(downN4),
        .score(score),
        .miss_cnt(miss_cnt)
`ifdef COMBO_EN
        ,
        .combo(combo)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int pulses;
        int score;
        int miss;
        int combo;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int m_score = 0;
    int m_miss = 0;
    int m_combo = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // 0 goal, 1 up, 2 down, 3 miss for lane index 0..3
    function automatic int judge(input int lane);
        int base;
        int zone;
        logic [15:0] row;
        base = 12 - 4 * lane;
        for (int z = 0; z < 3; z++) begin
            zone = (z == 0) ? 2 : (z == 1) ? 0 : 4;
            for (int r = zone; r < zone + 2; r++) begin
                row = pixels[r];
                for (int c = base; c < base + 4; c++)
                    if (row[c]) return z;
            end
        end
        return 3;
    endfunction

    function automatic int pulse_vec();
        return {downN4, downN3, downN2, downN1, upN4, upN3, upN2, upN1,
                goal4, goal3, goal2, goal1};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("pulses", pulse_vec(), e.pulses);
            chk("score", int'(score), e.score);
            chk("miss_cnt", int'(miss_cnt), e.miss);
`ifdef COMBO_EN
            chk("combo", int'(combo), e.combo);
`endif
        end else if (pulse_vec() != 0) begin
            chk("spurious_pulse", pulse_vec(), 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input bit accepted);
        exp_t e;
        int goals, nears, misses, k, gp;
        @(negedge clk);
        if (accepted) begin
            e.pulses = 0;
            goals = 0; nears = 0; misses = 0;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    k = judge(i);
                    if (k == 3) misses++;
                    else begin
                        e.pulses |= 1 << (4 * k + i);
                        if (k == 0) goals++; else nears++;
                    end
                end
            end
            gp = GP;
`ifdef COMBO_EN
            if (m_combo >= 4) gp = 2 * GP;
            if (nears + misses > 0) m_combo = 0;
            else if (goals > 0 && m_combo < 255) m_combo++;
`endif
            m_score += goals * gp + nears * NP;
            if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
            m_miss += misses;
            if (m_miss > 255) m_miss = 255;
            e.score = m_score;
            e.miss = m_miss;
            e.combo = m_combo;
            e.due = cyc + 4;
            q.push_back(e);
        end
        key = key | mask;
        repeat (hold) @(negedge clk);
        key = key & ~mask;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        key = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_score = 0;
        m_miss = 0;
        m_combo = 0;
    endtask

    initial begin
        apply_reset();
        chk("reset_score", int'(score), 0);
        chk("reset_miss", int'(miss_cnt), 0);
        chk("reset_pulses", pulse_vec(), 0);

        // lane1 goal with a 5-cycle press
        pixels[2][13] = 1'b1;
        press(4'b0001, 5, 1'b1);
        idle(10);

        // lane3: up beats down, then an empty window is a miss
        pixels = '0;
        pixels[0][5] = 1'b1;
        pixels[4][5] = 1'b1;
        press(4'b0100, 3, 1'b1);
        idle(1100);
        pixels = '0;
        press(4'b0100, 3, 1'b1);
        idle(10);

        // lane2: long hold yields one event; a repress inside lockout is ignored
        pixels[3][9] = 1'b1;
        press(4'b0010, 3000, 1'b1);
        idle(5);
        press(4'b0010, 5, 1'b1);
        idle(10);
        press(4'b0010, 5, 1'b0);
        idle(1100);
        press(4'b0010, 5, 1'b1);
        idle(10);

        // all lanes at once, repeated until the score clamps
        apply_reset();
        pixels = '0;
        pixels[2][13] = 1'b1;
        pixels[2][9]  = 1'b1;
        pixels[2][5]  = 1'b1;
        pixels[2][1]  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            press(4'b1111, 5, 1'b1);
            idle(1100);
        end

        // reset one cycle after key[3] rises drops the event
        apply_reset();
        @(negedge clk);
        key[3] = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        key = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(10);
        chk("rst_drop_score", int'(score), 0);
        chk("rst_drop_miss", int'(miss_cnt), 0);
        chk("rst_drop_pulses", pulse_vec(), 0);

`ifdef COMBO_EN
        apply_reset();
        pixels = '0;
        pixels[2][13] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            press(4'b0001, 3, 1'b1);
            idle(1100);
        end
        pixels = '0;
        press(4'b0001, 3, 1'b1);
        idle(10);
`endif

        idle(20);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
